// File: rtl/har_pkg.sv
// Shared constants and types for the single-layer-perceptron HAR sequencer.
package har_pkg;

    localparam int unsigned IMG_SIZE_DEF    = 95;
    localparam int unsigned NUM_CLASSES_DEF = 6;
    localparam int unsigned ACC_W           = 40;
    localparam int unsigned SCORE_W         = 32;

    localparam logic signed [SCORE_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [SCORE_W-1:0] SAT_MIN = 32'sh8000_0000;

    // Class index reported when the best score does not clear the threshold
    localparam logic [3:0] REJECT_CLASS = 4'(NUM_CLASSES_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/har_slp_sched_if.sv
// Feature stream, weight memory port and result stream of the HAR sequencer.
interface har_slp_sched_if #(
    parameter int unsigned IMG_SIZE    = 95,
    parameter int unsigned NUM_CLASSES = 6,
    parameter int unsigned M           = 15,
    parameter int unsigned N           = 15
) ();

    localparam int unsigned AW = $clog2(NUM_CLASSES * IMG_SIZE);

    logic                in_valid;
    logic                in_ready;
    logic signed [M:0]   in_data;
    logic                w_rd_en;
    logic [AW-1:0]       w_addr;
    logic signed [N:0]   w_data;
    logic                out_valid;
    logic                out_ready;
    logic [3:0]          out_class;
    logic signed [31:0]  out_score;

    // Environment side: feature producer, weight memory and result consumer
    modport master (
        output in_valid, in_data, w_data, out_ready,
        input  in_ready, w_rd_en, w_addr, out_valid, out_class, out_score
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_data, w_data, out_ready,
        output in_ready, w_rd_en, w_addr, out_valid, out_class, out_score
    );

endinterface

// File: rtl/har_mac_sat.sv
// Registered signed multiply followed by a wide accumulator that emits a
// saturated 32-bit total on the last product of each class.
module har_mac_sat
    import har_pkg::*;
#(
    parameter int unsigned FW    = 16,
    parameter int unsigned WW    = 16,
    parameter int unsigned ACC_W = har_pkg::ACC_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      mul_en,
    input  logic                      mul_last,
    input  logic signed [FW-1:0]      feat,
    input  logic signed [WW-1:0]      weight,
    output logic                      sum_valid,
    output logic signed [SCORE_W-1:0] sum_sat
);

    localparam int unsigned PW = FW + WW;

    logic signed [PW-1:0]    prod;
    logic                    p_v;
    logic                    p_last;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;

    // Product stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod   <= '0;
            p_v    <= 1'b0;
            p_last <= 1'b0;
        end else if (clr) begin
            prod   <= '0;
            p_v    <= 1'b0;
            p_last <= 1'b0;
        end else begin
            prod   <= PW'(feat) * PW'(weight);
            p_v    <= mul_en;
            p_last <= mul_last;
        end
    end

    // Running total including the product currently in the stage, clamped to 32 bits
    always_comb begin
        sum       = acc + ACC_W'(prod);
        sum_valid = p_v && p_last;
        if (sum > ACC_W'(SAT_MAX)) begin
            sum_sat = SAT_MAX;
        end else if (sum < ACC_W'(SAT_MIN)) begin
            sum_sat = SAT_MIN;
        end else begin
            sum_sat = SCORE_W'(sum);
        end
    end

    // Accumulator restarts at zero once a class total has been handed out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (p_v) begin
            acc <= p_last ? '0 : sum;
        end
    end

endmodule

// File: rtl/har_slp_sched.sv
// Single-layer-perceptron HAR sequencer: buffers one sample, streams all
// class weights through one MAC, tracks the argmax and reports the result.
module har_slp_sched
    import har_pkg::*;
#(
    parameter int unsigned IMG_SIZE    = IMG_SIZE_DEF,
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int unsigned M           = 15,
    parameter int unsigned N           = 15,
    parameter int unsigned ACC_W       = har_pkg::ACC_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      reset,
    har_slp_sched_if.slave            bus,
    input  logic signed [8:0]         Vth,
    input  logic [3:0]                score_sel,
    output logic signed [SCORE_W-1:0] score_rd,
    output logic                      busy
);

    localparam int unsigned TOTAL  = NUM_CLASSES * IMG_SIZE;
    localparam int unsigned AW     = $clog2(TOTAL);
    localparam int unsigned IW     = $clog2(IMG_SIZE);
    localparam logic [3:0]  REJECT = 4'(NUM_CLASSES);

    state_t                    state;
    logic [IW-1:0]             cnt;
    logic [1:0]                dcnt;
    logic                      d1_v;
    logic                      d1_last;
    logic [IW-1:0]             d1_i;
    logic [3:0]                wr_cls;
    logic signed [8:0]         vth_q;
    logic signed [SCORE_W-1:0] vth_ext;
    logic signed [SCORE_W-1:0] score [NUM_CLASSES];
    logic signed [SCORE_W-1:0] best_score;
    logic [3:0]                best_idx;
    logic signed [M:0]         feat [IMG_SIZE];
    logic                      accept;
    logic                      load_done;
    logic                      sum_valid;
    logic signed [SCORE_W-1:0] sum_sat;

    assign bus.in_ready = (state == S_IDLE) || (state == S_LOAD);
    assign busy         = (state == S_LOAD) || (state == S_COMPUTE) || (state == S_DRAIN);
    assign accept       = bus.in_valid && bus.in_ready;
    assign load_done    = accept && (cnt == IW'(IMG_SIZE - 1));
    assign vth_ext      = SCORE_W'(vth_q);

    // Feature buffer: contents only matter after a full sample, so no reset
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            feat[cnt] <= bus.in_data;
        end
    end

    // d1_* trails the issued read by one cycle so the feature lines up with w_data
    har_mac_sat #(
        .FW    (M + 1),
        .WW    (N + 1),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .clr       (reset || load_done),
        .mul_en    (d1_v),
        .mul_last  (d1_last),
        .feat      (feat[d1_i]),
        .weight    (bus.w_data),
        .sum_valid (sum_valid),
        .sum_sat   (sum_sat)
    );

    // Sequencer: load, issue reads, record class scores, present the answer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            dcnt          <= '0;
            d1_v          <= 1'b0;
            d1_last       <= 1'b0;
            d1_i          <= '0;
            wr_cls        <= '0;
            vth_q         <= '0;
            best_score    <= '0;
            best_idx      <= '0;
            bus.w_rd_en   <= 1'b0;
            bus.w_addr    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_class <= '0;
            bus.out_score <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) score[c] <= '0;
        end else if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            dcnt          <= '0;
            d1_v          <= 1'b0;
            d1_last       <= 1'b0;
            d1_i          <= '0;
            wr_cls        <= '0;
            vth_q         <= '0;
            best_score    <= '0;
            best_idx      <= '0;
            bus.w_rd_en   <= 1'b0;
            bus.w_addr    <= '0;
            bus.out_valid <= 1'b0;
            bus.out_class <= '0;
            bus.out_score <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) score[c] <= '0;
        end else begin
            d1_v    <= bus.w_rd_en;
            d1_i    <= cnt;
            d1_last <= (cnt == IW'(IMG_SIZE - 1));

            if (sum_valid) begin
                for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                    if (wr_cls == 4'(c)) score[c] <= sum_sat;
                end
                if (wr_cls == '0 || sum_sat > best_score) begin
                    best_score <= sum_sat;
                    best_idx   <= wr_cls;
                end
                wr_cls <= wr_cls + 4'd1;
            end

            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        if (load_done) begin
                            state       <= S_COMPUTE;
                            cnt         <= '0;
                            vth_q       <= Vth;
                            bus.w_rd_en <= 1'b1;
                            bus.w_addr  <= '0;
                            wr_cls      <= '0;
                            best_score  <= '0;
                            best_idx    <= '0;
                            for (int unsigned c = 0; c < NUM_CLASSES; c++) score[c] <= '0;
                        end else begin
                            state <= S_LOAD;
                            cnt   <= cnt + IW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (bus.w_addr == AW'(TOTAL - 1)) begin
                        state       <= S_DRAIN;
                        bus.w_rd_en <= 1'b0;
                        bus.w_addr  <= '0;
                        cnt         <= '0;
                        dcnt        <= '0;
                    end else begin
                        bus.w_addr <= bus.w_addr + AW'(1);
                        cnt        <= (cnt == IW'(IMG_SIZE - 1)) ? '0 : cnt + IW'(1);
                    end
                end
                S_DRAIN: begin
                    // Three cycles cover the memory and product stages of the final read
                    if (dcnt == 2'd2) begin
                        state         <= S_DONE;
                        bus.out_valid <= 1'b1;
                        bus.out_score <= best_score;
                        bus.out_class <= (best_score > vth_ext) ? best_idx : REJECT;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state         <= S_IDLE;
                        bus.out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Score readback; indices past the last class read as zero
    always_comb begin
        score_rd = '0;
        for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
            if (score_sel == 4'(c)) score_rd = score[c];
        end
    end

endmodule

// File: tb/tb_har_slp_sched.sv
// Self-checking bench for har_slp_sched against a dot-product reference model.
module tb_har_slp_sched;
    import har_pkg::*;

    localparam int IMG = 95;
    localparam int NC  = 6;
    localparam int TOT = IMG * NC;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              reset = 1'b0;
    logic signed [8:0] vth = '0;
    logic [3:0]        score_sel = '0;
    logic signed [31:0] score_rd;
    logic              busy;

    int cyc = 0;
    int hs_cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    logic signed [15:0] feat_v [IMG];
    logic signed [15:0] wmem [TOT];
    logic signed [31:0] exp_score [16];
    logic signed [31:0] obs [16];
    logic signed [31:0] exp_best;
    int                 exp_class;

    har_slp_sched_if bus ();

    har_slp_sched dut (
        .clk       (clk),
        .rst       (rst),
        .reset     (reset),
        .bus       (bus),
        .Vth       (vth),
        .score_sel (score_sel),
        .score_rd  (score_rd),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight memory: registered read, data valid the cycle after the strobe
    always @(posedge clk) if (bus.w_rd_en) bus.w_data <= wmem[bus.w_addr];

    // Reference: saturated dot product per class, first-max argmax, threshold
    task automatic ref_model();
        longint s;
        int best;
        for (int c = 0; c < 16; c++) exp_score[c] = '0;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int i = 0; i < IMG; i++) s += longint'(feat_v[i]) * longint'(wmem[c * IMG + i]);
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
            exp_score[c] = 32'(s);
        end
        best = 0;
        for (int c = 1; c < NC; c++) if (exp_score[c] > exp_score[best]) best = c;
        exp_best  = exp_score[best];
        exp_class = (exp_best > 32'(vth)) ? best : NC;
    endtask

    task automatic read_scores();
        for (int s = 0; s < 16; s++) begin
            score_sel = 4'(s);
            #1;
            obs[s] = score_rd;
        end
        score_sel = '0;
    endtask

    task automatic feed(input int count, input bit gap);
        for (int i = 0; i < count; i++) begin
            if (gap) begin bus.in_valid = 1'b0; @(posedge clk); #1; end
            bus.in_valid = 1'b1;
            bus.in_data  = feat_v[i];
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        hs_cyc = cyc;
    endtask

    task automatic wait_result(output bit got, output int lat);
        got = 1'b0;
        for (int k = 0; k < 800 && !got; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) got = 1'b1;
        end
        lat = cyc - hs_cyc;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < IMG; i++) feat_v[i] = 16'sd1;
        for (int a = 0; a < TOT; a++) wmem[a] = 16'(a / IMG + 1);
        vth = 9'sd10;
    endtask

    task automatic test_reset();
        #2; rst = 1'b0; #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        n_cmp++; if (bus.w_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_w_rd_en: got %0b expected 0", bus.w_rd_en); end
        n_cmp++; if (bus.w_addr !== '0) begin n_fail++; $display("FAIL reset_w_addr: got %0d expected 0", bus.w_addr); end
        n_cmp++; if (bus.out_class !== 4'd0) begin n_fail++; $display("FAIL reset_out_class: got %0d expected 0", bus.out_class); end
        n_cmp++; if (bus.out_score !== 32'sd0) begin n_fail++; $display("FAIL reset_out_score: got %0d expected 0", bus.out_score); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        read_scores();
        for (int s = 0; s < 16; s++) begin
            n_cmp++; if (obs[s] !== 32'sd0) begin n_fail++; $display("FAIL reset_score[%0d]: got %0d expected 0", s, obs[s]); end
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_weights();
        bit got; int lat;
        for (int i = 0; i < IMG; i++) feat_v[i] = 16'sd5;
        for (int a = 0; a < TOT; a++) wmem[a] = 16'sd0;
        vth = 9'sd10;
        ref_model();
        feed(IMG, 1'b0);
        wait_result(got, lat);
        n_cmp++; if (!got) begin n_fail++; $display("FAIL zero_timeout: got no out_valid expected out_valid"); end
        read_scores();
        for (int s = 0; s < 16; s++) begin
            n_cmp++; if (obs[s] !== exp_score[s]) begin n_fail++; $display("FAIL zero_score[%0d]: got %0d expected %0d", s, obs[s], exp_score[s]); end
        end
        n_cmp++; if (bus.out_class !== 4'd6) begin n_fail++; $display("FAIL zero_class: got %0d expected 6", bus.out_class); end
        n_cmp++; if (bus.out_score !== 32'sd0) begin n_fail++; $display("FAIL zero_out_score: got %0d expected 0", bus.out_score); end
        release_result();
    endtask

    task automatic test_ramp();
        bit got; int lat;
        load_ramp();
        ref_model();
        feed(IMG, 1'b0);
        wait_result(got, lat);
        n_cmp++; if (!got || lat != 573) begin n_fail++; $display("FAIL ramp_latency: got %0d expected 573", lat); end
        read_scores();
        for (int s = 0; s < 16; s++) begin
            n_cmp++; if (obs[s] !== exp_score[s]) begin n_fail++; $display("FAIL ramp_score[%0d]: got %0d expected %0d", s, obs[s], exp_score[s]); end
        end
        n_cmp++; if (bus.out_class !== 4'd5) begin n_fail++; $display("FAIL ramp_class: got %0d expected 5", bus.out_class); end
        n_cmp++; if (bus.out_score !== 32'sd570) begin n_fail++; $display("FAIL ramp_out_score: got %0d expected 570", bus.out_score); end
        release_result();
    endtask

    task automatic test_saturation();
        bit got; int lat;
        for (int i = 0; i < IMG; i++) feat_v[i] = 16'sd32767;
        for (int a = 0; a < TOT; a++) wmem[a] = (a / IMG == 2) ? 16'sd32767 : (a / IMG == 4) ? -16'sd32768 : 16'sd1;
        vth = 9'sd10;
        ref_model();
        feed(IMG, 1'b0);
        wait_result(got, lat);
        n_cmp++; if (!got) begin n_fail++; $display("FAIL sat_timeout: got no out_valid expected out_valid"); end
        read_scores();
        for (int s = 0; s < 16; s++) begin
            n_cmp++; if (obs[s] !== exp_score[s]) begin n_fail++; $display("FAIL sat_score[%0d]: got %0d expected %0d", s, obs[s], exp_score[s]); end
        end
        n_cmp++; if (obs[2] !== SAT_MAX) begin n_fail++; $display("FAIL sat_max: got %0d expected 2147483647", obs[2]); end
        n_cmp++; if (obs[4] !== SAT_MIN) begin n_fail++; $display("FAIL sat_min: got %0d expected -2147483648", obs[4]); end
        n_cmp++; if (bus.out_class !== 4'd2) begin n_fail++; $display("FAIL sat_class: got %0d expected 2", bus.out_class); end
        release_result();
    endtask

    task automatic test_stall_timing();
        bit got; int lat;
        for (int i = 0; i < IMG; i++) feat_v[i] = 16'($urandom_range(0, 2000)) - 16'sd1000;
        for (int a = 0; a < TOT; a++) wmem[a] = 16'($urandom_range(0, 2000)) - 16'sd1000;
        vth = 9'($urandom_range(0, 511));
        ref_model();
        feed(IMG, 1'b1);
        wait_result(got, lat);
        n_cmp++; if (!got || lat != 573) begin n_fail++; $display("FAIL stall_latency: got %0d expected 573", lat); end
        n_cmp++; if (bus.out_class !== 4'(exp_class)) begin n_fail++; $display("FAIL stall_class: got %0d expected %0d", bus.out_class, exp_class); end
        n_cmp++; if (bus.out_score !== exp_best) begin n_fail++; $display("FAIL stall_out_score: got %0d expected %0d", bus.out_score, exp_best); end
        // Offer junk input while stalled; it must not be taken
        bus.in_valid = 1'b1;
        bus.in_data  = 16'sh1234;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid: got %0b expected 1", bus.out_valid); end
            n_cmp++; if (bus.out_class !== 4'(exp_class)) begin n_fail++; $display("FAIL stall_hold_class: got %0d expected %0d", bus.out_class, exp_class); end
            n_cmp++; if (bus.out_score !== exp_best) begin n_fail++; $display("FAIL stall_hold_score: got %0d expected %0d", bus.out_score, exp_best); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %0b expected 0", bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        release_result();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %0b expected 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL release_idle: got in_ready=%0b busy=%0b expected in_ready=1 busy=0", bus.in_ready, busy); end
        read_scores();
        for (int s = 0; s < 16; s++) begin
            n_cmp++; if (obs[s] !== exp_score[s]) begin n_fail++; $display("FAIL idle_score[%0d]: got %0d expected %0d", s, obs[s], exp_score[s]); end
        end
    endtask

    task automatic test_random();
        bit got; int lat; int lo; int hi;
        for (int t = 0; t < 4; t++) begin
            // Alternate small operands (scores near threshold) with full range
            lo = (t % 2 == 0) ? 3 : 32768;
            hi = (t % 2 == 0) ? 3 : 32767;
            for (int i = 0; i < IMG; i++) feat_v[i] = 16'(int'($urandom_range(0, lo + hi)) - lo);
            for (int a = 0; a < TOT; a++) wmem[a] = 16'(int'($urandom_range(0, lo + hi)) - lo);
            vth = (t % 2 == 0) ? 9'(int'($urandom_range(0, 40)) - 20) : 9'($urandom_range(0, 511));
            ref_model();
            feed(IMG, 1'b0);
            wait_result(got, lat);
            n_cmp++; if (!got) begin n_fail++; $display("FAIL rand%0d_timeout: got no out_valid expected out_valid", t); end
            read_scores();
            for (int s = 0; s < 16; s++) begin
                n_cmp++; if (obs[s] !== exp_score[s]) begin n_fail++; $display("FAIL rand%0d_score[%0d]: got %0d expected %0d", t, s, obs[s], exp_score[s]); end
            end
            n_cmp++; if (bus.out_class !== 4'(exp_class)) begin n_fail++; $display("FAIL rand%0d_class: got %0d expected %0d", t, bus.out_class, exp_class); end
            n_cmp++; if (bus.out_score !== exp_best) begin n_fail++; $display("FAIL rand%0d_out_score: got %0d expected %0d", t, bus.out_score, exp_best); end
            release_result();
        end
    endtask

    task automatic test_soft_reset();
        bit got; int lat; int seen;
        load_ramp();
        feed(IMG, 1'b0);
        for (int k = 0; k < 200; k++) begin @(posedge clk); #1; end
        n_cmp++; if (bus.w_rd_en !== 1'b1) begin n_fail++; $display("FAIL sreset_pre_rd_en: got %0b expected 1", bus.w_rd_en); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (bus.w_rd_en !== 1'b0) begin n_fail++; $display("FAIL sreset_rd_en: got %0b expected 0", bus.w_rd_en); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL sreset_in_ready: got %0b expected 1", bus.in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sreset_busy: got %0b expected 0", busy); end
        score_sel = 4'd0; #1;
        n_cmp++; if (score_rd !== 32'sd0) begin n_fail++; $display("FAIL sreset_score0: got %0d expected 0", score_rd); end
        seen = 0;
        for (int k = 0; k < 650; k++) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) seen++; end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL sreset_no_result: got %0d valid cycles expected 0", seen); end
        ref_model();
        feed(IMG, 1'b0);
        wait_result(got, lat);
        n_cmp++; if (!got || lat != 573) begin n_fail++; $display("FAIL sreset_rerun_latency: got %0d expected 573", lat); end
        n_cmp++; if (bus.out_class !== 4'd5) begin n_fail++; $display("FAIL sreset_rerun_class: got %0d expected 5", bus.out_class); end
        n_cmp++; if (bus.out_score !== 32'sd570) begin n_fail++; $display("FAIL sreset_rerun_score: got %0d expected 570", bus.out_score); end
        release_result();
    endtask

    task automatic test_async_reset();
        bit got; int lat;
        load_ramp();
        for (int i = 0; i < IMG; i++) feat_v[i] = 16'sd7;
        feed(40, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL areset_pre_busy: got %0b expected 1", busy); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %0b expected 1", bus.in_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %0b expected 0", busy); end
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.w_rd_en !== 1'b0) begin n_fail++; $display("FAIL areset_strobes: got valid=%0b rd_en=%0b expected 0 0", bus.out_valid, bus.w_rd_en); end
        n_cmp++; if (bus.out_class !== 4'd0) begin n_fail++; $display("FAIL areset_out_class: got %0d expected 0", bus.out_class); end
        n_cmp++; if (bus.out_score !== 32'sd0) begin n_fail++; $display("FAIL areset_out_score: got %0d expected 0", bus.out_score); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        load_ramp();
        ref_model();
        feed(IMG, 1'b0);
        wait_result(got, lat);
        n_cmp++; if (!got || lat != 573) begin n_fail++; $display("FAIL areset_rerun_latency: got %0d expected 573", lat); end
        n_cmp++; if (bus.out_class !== 4'd5) begin n_fail++; $display("FAIL areset_rerun_class: got %0d expected 5", bus.out_class); end
        n_cmp++; if (bus.out_score !== 32'sd570) begin n_fail++; $display("FAIL areset_rerun_score: got %0d expected 570", bus.out_score); end
        release_result();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_zero_weights();
        test_ramp();
        test_saturation();
        test_stall_timing();
        test_random();
        test_soft_reset();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/har_slp_sched.md
Name: har_slp_sched

Overview:
- Sequencer for the single-layer-perceptron HAR classifier.
- Accepts one 95-feature sample over a valid/ready stream and buffers it.
- Time-multiplexes one signed MAC over all NUM_CLASSES x IMG_SIZE weights, read from an external weight memory.
- Returns saturated 32-bit class scores and a thresholded argmax class through an output valid/ready handshake.

Parameters:
IMG_SIZE, 95, features per sample
NUM_CLASSES, 6, output classes (max 15)
M, 15, feature MSB (features are M+1 bits signed)
N, 15, weight MSB (weights are N+1 bits signed)
ACC_W, 40, internal accumulator width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
reset  in  1  synchronous soft clear, active-high
in_valid  in  1  feature word valid
in_ready  out  1  block can accept a feature
in_data  in  M+1  signed feature
w_rd_en  out  1  weight memory read strobe
w_addr  out  clog2(NUM_CLASSES*IMG_SIZE)  weight address, class-major (c*IMG_SIZE+i)
w_data  in  N+1  signed weight, valid the cycle after w_rd_en
Vth  in  9  signed score threshold
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_class  out  4  argmax class, or NUM_CLASSES for reject
out_score  out  32  winning score
score_sel  in  4  score read index
score_rd  out  32  score[score_sel], combinational
busy  out  1  high in LOAD, COMPUTE, DRAIN

Behaviour:
- Reset values (rst low, async): state IDLE, in_ready=1, out_valid=0, w_rd_en=0, w_addr=0, out_class=0, out_score=0, all scores=0, busy=0.
- reset=1 (sync): identical clear on the next edge; has priority over every handshake in the same cycle.
- States: IDLE, LOAD, COMPUTE, DRAIN, DONE.
- IDLE/LOAD: in_ready=1. Each in_valid&&in_ready writes feat[cnt] and increments cnt. The first accept moves IDLE->LOAD. The IMG_SIZE-th accept moves to COMPUTE and clears cnt.
- COMPUTE: in_ready=0. Vth is sampled on entry. One read is issued per cycle (w_rd_en=1), addr 0..NUM_CLASSES*IMG_SIZE-1, no gaps. After the last issue, move to DRAIN.
- Pipeline: cycle k issues addr; k+1 registers the product feat[i]*w_data (32-bit signed); k+2 accumulates into ACC_W. On the last feature of a class, the accumulator value (including that product) is saturated to 32 bits, written to score[c], and the accumulator restarts at 0 for the next class.
- Saturation: above 2147483647 gives 2147483647; below -2147483648 gives -2147483648.
- Argmax: updated incrementally on each score write. Strictly-greater comparison, so ties resolve to the lowest index. Class 0 initialises best.
- DRAIN: 3 cycles. Then DONE with out_valid=1.
- out_valid asserts exactly NUM_CLASSES*IMG_SIZE+3 cycles after the final feature handshake: 573 for defaults.
- Threshold: if best score > sign-extended Vth, out_class=best index; otherwise out_class=NUM_CLASSES (reject). out_score=best score in both cases.
- DONE: out_valid, out_class and out_score are held stable until out_ready. On out_valid&&out_ready, go to IDLE; out_valid drops the next cycle.
- in_ready stays 0 in COMPUTE, DRAIN and DONE; in_valid is ignored there.
- score_rd reflects the last completed writes. Values are meaningful in DONE and stay held in IDLE until the next COMPUTE entry clears them.
- score_sel >= NUM_CLASSES returns 0.
- Reset mid-operation (either reset): partial sample and scores are discarded, no out_valid is produced, the next sample processes normally.

Decomposition:
- Package har_pkg holds: IMG_SIZE/NUM_CLASSES defaults, ACC_W, SCORE_W=32, SAT_MAX/SAT_MIN constants, REJECT_CLASS, state enum.
- One sub-module, har_mac_sat: registered multiply, ACC_W accumulate, clear-on-start, saturating 32-bit output.
- Feature buffer, address counters, FSM and argmax stay in har_slp_sched.

Test Plan:
- All weights 0, all features 5, Vth=10 -> all scores 0, out_score=0, out_class=6 (reject via tie to class 0 below threshold).
- Features all 1, class c weights all c+1, Vth=10 -> scores 95,190,285,380,475,570; out_class=5; out_score=570.
- Features all 32767, class 2 weights 32767, class 4 weights -32768, others 1 -> score[2]=2147483647, score[4]=-2147483648, out_class=2.
- Feed 95 features with in_valid toggled every other cycle, out_ready held 0 for 10 cycles -> out_valid exactly 573 cycles after the last handshake. Outputs stable while stalled, in_ready=0, IDLE the cycle after out_ready rises.
- Assert reset at cycle 200 of COMPUTE -> w_rd_en=0 and in_ready=1 the next cycle, no out_valid. A following sample gives the same result as the second scenario.
- Drop rst asynchronously mid-clock during LOAD -> all outputs reach reset values immediately with no clock edge.
